// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle memory access unit.
package mem_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Fetches are always word sized; reserved encodings fall back to word.
   function automatic size_t access_size(input logic [2:0] funct3, input logic fetch);
      size_t sz;
      sz = SZ_WORD;
      if (!fetch) begin
         case (funct3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] addr_lo);
      logic mis;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         default: mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables and store replication for writes,
// lane extraction and sign/zero extension for reads.
module load_store_align
   import mem_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic            fetch,
   input  logic            is_store,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [BE_W-1:0] be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);

   size_t       sz;
   logic        sign_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign sz       = access_size(funct3, fetch);
   assign sign_ext = ~funct3[2];
   assign byte_v   = 8'(rdata >> {addr_lo, 3'b000});
   assign half_v   = 16'(rdata >> {addr_lo[1], 4'b0000});

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
      be        = '1;
      wdata     = store_data;
      load_data = rdata;
      case (sz)
         SZ_BYTE: begin
            load_data = {{(XLEN-8){sign_ext & byte_v[7]}}, byte_v};
            wdata     = {4{store_data[7:0]}};
            if (is_store) be = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            load_data = {{(XLEN-16){sign_ext & half_v[15]}}, half_v};
            wdata     = {2{store_data[15:0]}};
            if (is_store) be = 4'b0011 << {addr_lo[1], 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle req/ack memory port: FSM, access latches, timeout and the IR.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int              TIMEOUT  = 16,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            adr_src,
   input  logic            mem_write,
   input  logic            ir_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [BE_W-1:0] mem_be,
   output logic            mem_req,
   output logic            mem_we,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] old_pc,
   output logic [XLEN-1:0] load_data,
   output logic            busy,
   output logic            done,
   output logic            bus_err,
   output logic            misaligned
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [XLEN-1:0]  addr_q, addr_d, pc_q, pc_d, wdata_q, wdata_d;
   logic [XLEN-1:0]  instr_q, instr_d, old_pc_q, old_pc_d, load_q, load_d;
   logic [BE_W-1:0]  be_q, be_d;
   logic [2:0]       f3_q, f3_d;
   logic             we_q, we_d, fetch_q, fetch_d, err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MISALIGN_TRAP_EN
   logic             mis_q, mis_d;
`endif

   logic            idle;
   logic [XLEN-1:0] eff_addr;
   logic [2:0]      al_f3;
   logic            al_fetch, al_store;
   logic [1:0]      al_lo;
   logic [BE_W-1:0] al_be;
   logic [XLEN-1:0] al_wdata, al_load;

   assign idle     = (state_q == IDLE);
   assign eff_addr = adr_src ? alu_result : pc;

   // Lane logic sees the live request at start and the latched one while in flight.
   assign al_f3    = idle ? funct3         : f3_q;
   assign al_fetch = idle ? ir_write       : fetch_q;
   assign al_store = idle ? mem_write      : we_q;
   assign al_lo    = idle ? eff_addr[1:0]  : addr_q[1:0];

   load_store_align u_align (
      .funct3     (al_f3),
      .fetch      (al_fetch),
      .is_store   (al_store),
      .addr_lo    (al_lo),
      .store_data (write_data),
      .rdata      (mem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      pc_d     = pc_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      f3_d     = f3_q;
      we_d     = we_q;
      fetch_d  = fetch_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      instr_d  = instr_q;
      old_pc_d = old_pc_q;
      load_d   = load_q;
`ifdef MISALIGN_TRAP_EN
      mis_d    = mis_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            addr_d  = eff_addr;
            pc_d    = pc;
            f3_d    = funct3;
            we_d    = mem_write;
            fetch_d = ir_write;
            be_d    = al_be;
            wdata_d = al_wdata;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
`ifdef MISALIGN_TRAP_EN
            mis_d   = is_misaligned(access_size(funct3, ir_write), eff_addr[1:0]);
            if (mis_d) state_d = RESP;
`endif
         end
         REQ: begin
            if (mem_ack) begin
               state_d = RESP;
               if (fetch_q) begin
                  instr_d  = mem_rdata;
                  old_pc_d = pc_q;
               end else if (!we_q) begin
                  load_d = al_load;
               end
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               state_d = RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         pc_q     <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         f3_q     <= '0;
         we_q     <= 1'b0;
         fetch_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         instr_q  <= '0;
         old_pc_q <= RESET_PC;
         load_q   <= '0;
`ifdef MISALIGN_TRAP_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         pc_q     <= pc_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         f3_q     <= f3_d;
         we_q     <= we_d;
         fetch_q  <= fetch_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         old_pc_q <= old_pc_d;
         load_q   <= load_d;
`ifdef MISALIGN_TRAP_EN
         mis_q    <= mis_d;
`endif
      end
   end

   assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign mem_req   = (state_q == REQ);
   assign mem_we    = mem_req & we_q;
   assign instr     = instr_q;
   assign old_pc    = old_pc_q;
   assign load_data = load_q;
   assign busy      = ~idle | start;
   assign done      = (state_q == RESP);
   assign bus_err   = done & err_q;
`ifdef MISALIGN_TRAP_EN
   assign misaligned = done & mis_q;
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: schedule-based reference model plus directed literals.
module tb_mem_access_unit;

   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset, start, adr_src, mem_write, ir_write;
   logic [2:0]  funct3;
   logic [31:0] pc, alu_result, write_data;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] instr, old_pc, load_data;
   logic        busy, done, bus_err, misaligned;

   int          cyc     = 0;
   int          ack_cyc = -1;
   logic [31:0] rd_val  = '0;
   int          n_pass  = 0;
   int          n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: acks in exactly the cycle the current transaction schedules.
   assign mem_ack   = (cyc == ack_cyc);
   assign mem_rdata = rd_val;

   mem_access_unit #(.TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .funct3     (funct3),
      .pc         (pc),
      .alu_result (alu_result),
      .write_data (write_data),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .instr      (instr),
      .old_pc     (old_pc),
      .load_data  (load_data),
      .busy       (busy),
      .done       (done),
      .bus_err    (bus_err),
      .misaligned (misaligned)
   );

   // Reference model: a per-transaction schedule of cycle numbers and expected values.
   int          m_start = -1, m_done = -1, m_req_lo = -1, m_req_hi = -2;
   logic        m_err = 1'b0, m_mis = 1'b0, m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [3:0]  m_be = '0;
   logic [31:0] m_instr = '0, m_old_pc = RESET_PC, m_load = '0;
   logic        p_fetch = 1'b0, p_load = 1'b0;
   logic [31:0] p_val = '0, p_pc = '0;
   logic        cmp_en = 1'b0;
   logic        e_req, e_done, e_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      check(name, 32'(act), 32'(exp));
   endtask

   function automatic int m_size(input logic [2:0] f3, input logic fetch);
      if (fetch) return 4;
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load_fn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      int unsigned v;
      v = rd;
      if (m_size(f3, 1'b0) == 1) begin
         v = (rd >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
         if (f3 == 3'b000 && v >= 128) v = v - 256;
      end else if (m_size(f3, 1'b0) == 2) begin
         v = (rd >> (16 * int'(a[1]))) & 32'h0000_FFFF;
         if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   // Issue one access in the current cycle; w = wait cycles before ack, -1 = never ack.
   task automatic launch(input logic src, input logic we, input logic fetch, input logic [2:0] f3,
                         input logic [31:0] pcv, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] rd, input int w, output int c);
      logic [31:0] eff;
      int          sz, n;
      logic        trap, timed;
      c    = cyc;
      eff  = src ? alu : pcv;
      sz   = m_size(f3, fetch);
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = (sz == 2 && eff[0]) || (sz == 4 && eff[1:0] != 2'b00);
`endif
      start = 1'b1; adr_src = src; mem_write = we; ir_write = fetch; funct3 = f3;
      pc = pcv; alu_result = alu; write_data = wd; rd_val = rd;
      m_start = c; m_mis = trap; m_we = we; m_addr = {eff[31:2], 2'b00};
      m_be = 4'hF; m_wdata = wd;
      if (we && sz == 1) begin
         m_be = 4'(1 << int'(eff[1:0])); m_wdata = {4{wd[7:0]}};
      end else if (we && sz == 2) begin
         m_be = 4'(3 << (2 * int'(eff[1]))); m_wdata = {2{wd[15:0]}};
      end
      if (trap) begin
         m_req_lo = -1; m_req_hi = -2; m_done = c + 1; m_err = 1'b0;
         ack_cyc = -1; p_fetch = 1'b0; p_load = 1'b0;
      end else begin
         timed    = (w < 0 || w >= TIMEOUT);
         n        = timed ? TIMEOUT : w + 1;
         m_req_lo = c + 1; m_req_hi = c + n; m_done = c + n + 1; m_err = timed;
         ack_cyc  = timed ? -1 : c + 1 + w;
         p_fetch  = !timed && fetch;
         p_load   = !timed && !fetch && !we;
         p_val    = fetch ? rd : m_load_fn(f3, eff, rd);
         p_pc     = pcv;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_start = -1; m_done = -1; m_req_lo = -1; m_req_hi = -2;
      m_err = 1'b0; m_mis = 1'b0; ack_cyc = -1; p_fetch = 1'b0; p_load = 1'b0;
      m_instr = '0; m_old_pc = RESET_PC; m_load = '0;
   endtask

   // Compare process: every cycle outside reset, DUT against the model schedule.
   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         if (cyc == m_done) begin
            if (p_fetch) begin m_instr = p_val; m_old_pc = p_pc; end
            if (p_load) m_load = p_val;
            p_fetch = 1'b0; p_load = 1'b0;
         end
         e_req  = (cyc >= m_req_lo && cyc <= m_req_hi);
         e_done = (cyc == m_done);
         e_busy = (m_start >= 0 && cyc >= m_start && cyc <= m_done);
         check_b("mem_req", mem_req, e_req);
         check_b("done", done, e_done);
         check_b("bus_err", bus_err, e_done && m_err);
         check_b("misaligned", misaligned, e_done && m_mis);
         check_b("busy", busy, e_busy);
         check("instr", instr, m_instr);
         check("old_pc", old_pc, m_old_pc);
         check("load_data", load_data, m_load);
         check_b("mem_we", mem_we, e_req && m_we);
         if (e_req) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_be", 32'(mem_be), 32'(m_be));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
         end
      end
   end

   initial begin
      int c;
      reset = 1'b1; start = 1'b0; adr_src = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
      funct3 = 3'b000; pc = '0; alu_result = '0; write_data = '0;
      @(posedge clk); #1;
      do_reset();
      check_b("rst_req", mem_req, 1'b0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_be", 32'(mem_be), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_old_pc", old_pc, 32'h0000_0100);
      check("rst_instr", instr, 32'h0);
      check_b("rst_busy", busy, 1'b0);
      cmp_en = 1'b1;

      // Zero-wait fetch.
      launch(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0030_0093, 0, c);
      check("fetch_addr", mem_addr, 32'h10);
      check("fetch_be", 32'(mem_be), 32'hF);
      check_b("fetch_we", mem_we, 1'b0);
      wait_to(c + 2);
      check_b("fetch_done", done, 1'b1);
      check("fetch_instr", instr, 32'h0030_0093);
      check("fetch_old_pc", old_pc, 32'h10);
      wait_to(c + 3);

      // lb / lbu from the top byte lane.
      launch(1'b1, 1'b0, 1'b0, 3'b000, 32'h14, 32'h103, 32'h0, 32'h80FF_FFFF, 0, c);
      wait_to(c + 2);
      check("lb_data", load_data, 32'hFFFF_FF80);
      wait_to(c + 3);
      launch(1'b1, 1'b0, 1'b0, 3'b100, 32'h14, 32'h103, 32'h0, 32'h80FF_FFFF, 0, c);
      wait_to(c + 2);
      check("lbu_data", load_data, 32'h0000_0080);
      wait_to(c + 3);

      // sh to the upper half, one wait cycle; sb to lane 1.
      launch(1'b1, 1'b1, 1'b0, 3'b001, 32'h18, 32'h202, 32'h1234_ABCD, 32'h0, 1, c);
      check("sh_addr", mem_addr, 32'h200);
      check("sh_be", 32'(mem_be), 32'hC);
      check("sh_wdata_hi", 32'(mem_wdata[31:16]), 32'hABCD);
      check_b("sh_we", mem_we, 1'b1);
      wait_to(c + 4);
      launch(1'b1, 1'b1, 1'b0, 3'b000, 32'h1C, 32'h101, 32'h0000_00AB, 32'h0, 0, c);
      check("sb_be", 32'(mem_be), 32'h2);
      check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      wait_to(c + 3);

      // lw with 3 wait cycles and a stray start pulse mid-wait.
      launch(1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'h300, 32'h0, 32'hCAFE_F00D, 3, c);
      wait_to(c + 2);
      start = 1'b1; mem_write = 1'b1; alu_result = 32'h400;
      wait_to(c + 3);
      start = 1'b0;
      check("wait_addr", mem_addr, 32'h300);
      wait_to(c + 5);
      check_b("wait_done", done, 1'b1);
      check("wait_data", load_data, 32'hCAFE_F00D);
      wait_to(c + 6);

      // Halfword loads, including an odd address.
      launch(1'b1, 1'b0, 1'b0, 3'b001, 32'h24, 32'h306, 32'h0, 32'h8001_7FFF, 0, c);
      wait_to(c + 2);
      check("lh_data", load_data, 32'hFFFF_8001);
      wait_to(c + 3);
      launch(1'b1, 1'b0, 1'b0, 3'b101, 32'h24, 32'h306, 32'h0, 32'h8001_7FFF, 0, c);
      wait_to(c + 3);
      launch(1'b1, 1'b0, 1'b0, 3'b101, 32'h24, 32'h103, 32'h0, 32'h1234_5678, 0, c);
      wait_to(c + 3);
      launch(1'b1, 1'b0, 1'b0, 3'b011, 32'h24, 32'h104, 32'h0, 32'h5555_AAAA, 0, c);
      wait_to(c + 3);

      // Fetch with no ack: timeout after TIMEOUT request cycles, IR untouched.
      launch(1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 32'hFFFF_FFFF, -1, c);
      wait_to(c + 16);
      check_b("to_last_req", mem_req, 1'b1);
      wait_to(c + 17);
      check_b("to_done", done, 1'b1);
      check_b("to_err", bus_err, 1'b1);
      check("to_instr", instr, 32'h0030_0093);
      wait_to(c + 18);

      // Misaligned word access.
      launch(1'b1, 1'b0, 1'b0, 3'b010, 32'h44, 32'h102, 32'h0, 32'h1111_2222, 0, c);
`ifdef MISALIGN_TRAP_EN
      check_b("mis_req", mem_req, 1'b0);
      check_b("mis_done", done, 1'b1);
      check_b("mis_flag", misaligned, 1'b1);
      wait_to(c + 2);
`else
      check("trunc_addr", mem_addr, 32'h100);
      wait_to(c + 2);
      check_b("trunc_mis", misaligned, 1'b0);
      check("trunc_data", load_data, 32'h1111_2222);
`endif
      wait_to(c + 3);

      // Reset during a REQ wait cycle.
      launch(1'b1, 1'b0, 1'b0, 3'b010, 32'h48, 32'h500, 32'h0, 32'h0, -1, c);
      wait_to(c + 2);
      do_reset();
      check_b("rreq_req", mem_req, 1'b0);
      check_b("rreq_busy", busy, 1'b0);
      check_b("rreq_done", done, 1'b0);
      check("rreq_old_pc", old_pc, 32'h0000_0100);
      wait_to(cyc + 20);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
